// File: rtl/bus_reg_bank.sv
// -----------------------------------------------------------------------------
// bus_reg_bank
//   Bank of DEPTH registers, each WIDTH bits, attached to a shared tri-state
//   bus. Any register can be loaded from the bus, driven onto the bus, or
//   counted up/down. Registers are also exposed in parallel for debug.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; clears registers, wrap and err
//   DATA     io   shared bus, driven only while enable=1
//   latch    in   load DATA into reg[wsel]
//   wsel     in   write select
//   enable   in   drive reg[rsel] onto DATA (zeros if rsel is out of range)
//   rsel     in   read select
//   inc      in   increment reg[csel]
//   dec      in   decrement reg[csel]
//   csel     in   count select
//   REG_OUT  out  all registers, reg[i] at [i*WIDTH +: WIDTH]
//   zero     out  combinational, reg[csel] == 0
//   wrap     out  one-cycle pulse after a count wraps past all-ones or zero
//   err      out  sticky, set by any out-of-range select; cleared by reset
// -----------------------------------------------------------------------------
module bus_reg_bank #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    inout  wire  [WIDTH-1:0]       DATA,
    input  logic                   latch,
    input  logic [AW-1:0]          wsel,
    input  logic                   enable,
    input  logic [AW-1:0]          rsel,
    input  logic                   inc,
    input  logic                   dec,
    input  logic [AW-1:0]          csel,
    output logic [WIDTH*DEPTH-1:0] REG_OUT,
    output logic                   zero,
    output logic                   wrap,
    output logic                   err
);

    // Selects are widened by one bit before the range check so the compare
    // is not constant when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_wrap;
    logic             r_err;

    logic             w_wsel_ok;
    logic             w_rsel_ok;
    logic             w_csel_ok;
    logic             w_wr_en;
    logic             w_cnt_en;
    logic             w_wrap_next;
    logic             w_err_set;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_cval;

    assign w_wsel_ok = ({1'b0, wsel} < DEPTH_W);
    assign w_rsel_ok = ({1'b0, rsel} < DEPTH_W);
    assign w_csel_ok = ({1'b0, csel} < DEPTH_W);

    assign w_wr_en = latch & w_wsel_ok;

    // inc and dec together cancel; a load to the same register wins over
    // the count and suppresses its wrap.
    assign w_cnt_en = (inc ^ dec) & w_csel_ok & ~(w_wr_en & (wsel == csel));

    // Out-of-range selects read as zero on both the bus and the count path.
    always_comb begin
        w_rdata = '0;
        w_cval  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rsel == AW'(i)) w_rdata = r_regs[i];
            if (csel == AW'(i)) w_cval  = r_regs[i];
        end
    end

    assign w_wrap_next = w_cnt_en & ((inc & (&w_cval)) | (dec & ~(|w_cval)));

    assign w_err_set = (latch & ~w_wsel_ok)
                     | ((inc | dec) & ~w_csel_ok)
                     | (enable & ~w_rsel_ok);

    assign DATA = enable ? w_rdata : 'z;
    assign zero = (w_cval == '0);
    assign wrap = r_wrap;
    assign err  = r_err;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_regout
            assign REG_OUT[g*WIDTH +: WIDTH] = r_regs[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_wr_en && (wsel == AW'(i))) begin
                    r_regs[i] <= DATA;
                end else if (w_cnt_en && (csel == AW'(i))) begin
                    r_regs[i] <= inc ? r_regs[i] + WIDTH'(1)
                                     : r_regs[i] - WIDTH'(1);
                end
            end
            r_wrap <= w_wrap_next;
            r_err  <= r_err | w_err_set;
        end
    end

endmodule

// File: tb/tb_bus_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_bus_reg_bank
//   Directed bench for bus_reg_bank: a default instance (16x8) and a DEPTH=6
//   instance for out-of-range selects. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_bus_reg_bank;

    logic clk;
    logic reset;

    // default instance
    wire  [15:0]  DATA;
    logic [15:0]  drv;
    logic         drv_en;
    logic         latch, enable, inc, dec;
    logic [2:0]   wsel, rsel, csel;
    logic [127:0] reg_out;
    logic         zero, wrap, err;

    // DEPTH=6 instance
    wire  [15:0]  DATA6;
    logic [15:0]  drv6;
    logic         drv6_en;
    logic         latch6, enable6, inc6, dec6;
    logic [2:0]   wsel6, rsel6, csel6;
    logic [95:0]  reg_out6;
    logic         zero6, wrap6, err6;

    int total = 0;
    int bad   = 0;

    assign DATA  = drv_en  ? drv  : 'z;
    assign DATA6 = drv6_en ? drv6 : 'z;

    bus_reg_bank #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .DATA(DATA),
        .latch(latch), .wsel(wsel), .enable(enable), .rsel(rsel),
        .inc(inc), .dec(dec), .csel(csel),
        .REG_OUT(reg_out), .zero(zero), .wrap(wrap), .err(err)
    );

    bus_reg_bank #(.WIDTH(16), .DEPTH(6)) dut6 (
        .clk(clk), .reset(reset), .DATA(DATA6),
        .latch(latch6), .wsel(wsel6), .enable(enable6), .rsel(rsel6),
        .inc(inc6), .dec(dec6), .csel(csel6),
        .REG_OUT(reg_out6), .zero(zero6), .wrap(wrap6), .err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] reg_of(input int i);
        return reg_out[i*16 +: 16];
    endfunction

    function automatic logic [15:0] reg6_of(input int i);
        return reg_out6[i*16 +: 16];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_main;
        latch = 0; enable = 0; inc = 0; dec = 0; drv_en = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        tick();
        reset = 0;
        total++; if (reg_out !== 128'h0) begin bad++; $display("FAIL reset_regout: got %h want 0", reg_out); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", zero); end
        total++; if (reg_out6 !== 96'h0) begin bad++; $display("FAIL reset_regout6: got %h want 0", reg_out6); end
    endtask

    task automatic test_read_write;
        drv = 16'hBEEF; drv_en = 1; latch = 1; wsel = 3;
        tick();
        clear_main();
        total++; if (reg_of(3) !== 16'hBEEF) begin bad++; $display("FAIL rw_reg3: got %h want beef", reg_of(3)); end
        total++; if (reg_of(2) !== 16'h0 || reg_of(4) !== 16'h0) begin bad++; $display("FAIL rw_neighbours: got %h %h want 0 0", reg_of(2), reg_of(4)); end
        enable = 1; rsel = 3;
        #1;
        total++; if (DATA !== 16'hBEEF) begin bad++; $display("FAIL rw_bus_read: got %h want beef", DATA); end
        // With enable low the DUT must release the bus: an external 0 reads back.
        enable = 0; drv = 16'h0000; drv_en = 1;
        #1;
        total++; if (DATA !== 16'h0000) begin bad++; $display("FAIL rw_bus_release: got %h want 0000", DATA); end
        drv_en = 0;
    endtask

    task automatic test_inc_wrap;
        drv = 16'hFFFF; drv_en = 1; latch = 1; wsel = 2;
        tick();
        clear_main();
        inc = 1; csel = 2;
        #1;
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL incw_zero_before: got %b want 0", zero); end
        tick();
        inc = 0;
        total++; if (reg_of(2) !== 16'h0000) begin bad++; $display("FAIL incw_reg2: got %h want 0000", reg_of(2)); end
        total++; if (wrap !== 1'b1) begin bad++; $display("FAIL incw_wrap: got %b want 1", wrap); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL incw_zero_after: got %b want 1", zero); end
        tick();
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL incw_wrap_end: got %b want 0", wrap); end
    endtask

    task automatic test_dec_wrap;
        dec = 1; csel = 0;
        tick();
        dec = 0;
        total++; if (reg_of(0) !== 16'hFFFF) begin bad++; $display("FAIL decw_reg0: got %h want ffff", reg_of(0)); end
        total++; if (wrap !== 1'b1) begin bad++; $display("FAIL decw_wrap: got %b want 1", wrap); end
        tick();
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL decw_wrap_end: got %b want 0", wrap); end
        dec = 1; csel = 3;
        tick();
        dec = 0;
        total++; if (reg_of(3) !== 16'hBEEE) begin bad++; $display("FAIL dec_reg3: got %h want beee", reg_of(3)); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dec_nowrap: got %b want 0", wrap); end
    endtask

    task automatic test_latch_priority;
        drv = 16'h1234; drv_en = 1; latch = 1; wsel = 5; inc = 1; csel = 5;
        tick();
        clear_main();
        total++; if (reg_of(5) !== 16'h1234) begin bad++; $display("FAIL prio_reg5: got %h want 1234", reg_of(5)); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL prio_wrap: got %b want 0", wrap); end
        inc = 1; dec = 1; csel = 5;
        tick();
        clear_main();
        total++; if (reg_of(5) !== 16'h1234) begin bad++; $display("FAIL incdec_reg5: got %h want 1234", reg_of(5)); end
        // reg2 is zero: a lone dec would wrap, the pair must not
        inc = 1; dec = 1; csel = 2;
        tick();
        clear_main();
        total++; if (reg_of(2) !== 16'h0000) begin bad++; $display("FAIL incdec_reg2: got %h want 0000", reg_of(2)); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL incdec_wrap: got %b want 0", wrap); end
    endtask

    task automatic test_different_regs;
        drv = 16'h00AA; drv_en = 1; latch = 1; wsel = 1; inc = 1; csel = 5;
        tick();
        clear_main();
        total++; if (reg_of(1) !== 16'h00AA) begin bad++; $display("FAIL diff_reg1: got %h want 00aa", reg_of(1)); end
        total++; if (reg_of(5) !== 16'h1235) begin bad++; $display("FAIL diff_reg5: got %h want 1235", reg_of(5)); end
        // reg0 is ffff: wrap on the count path alongside a load elsewhere
        drv = 16'h0007; drv_en = 1; latch = 1; wsel = 4; inc = 1; csel = 0;
        tick();
        clear_main();
        total++; if (reg_of(4) !== 16'h0007) begin bad++; $display("FAIL diff_reg4: got %h want 0007", reg_of(4)); end
        total++; if (reg_of(0) !== 16'h0000) begin bad++; $display("FAIL diff_reg0: got %h want 0000", reg_of(0)); end
        total++; if (wrap !== 1'b1) begin bad++; $display("FAIL diff_wrap: got %b want 1", wrap); end
    endtask

    task automatic test_self_drive;
        enable = 1; rsel = 5; latch = 1; wsel = 5;
        tick();
        clear_main();
        total++; if (reg_of(5) !== 16'h1235) begin bad++; $display("FAIL self_reg5: got %h want 1235", reg_of(5)); end
        total++; if (reg_of(1) !== 16'h00AA) begin bad++; $display("FAIL self_reg1: got %h want 00aa", reg_of(1)); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL self_err: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_count;
        drv = 16'hFFFF; drv_en = 1; latch = 1; wsel = 2;
        tick();
        clear_main();
        reset = 1; inc = 1; csel = 2; enable = 1; rsel = 3;
        #1;
        total++; if (DATA !== 16'hBEEE) begin bad++; $display("FAIL rstmid_bus_pre: got %h want beee", DATA); end
        tick();
        total++; if (reg_out !== 128'h0) begin bad++; $display("FAIL rstmid_regout: got %h want 0", reg_out); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL rstmid_wrap: got %b want 0", wrap); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %b want 0", err); end
        total++; if (DATA !== 16'h0000) begin bad++; $display("FAIL rstmid_bus: got %h want 0000", DATA); end
        reset = 0;
        clear_main();
        tick();
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL rstmid_wrap_after: got %b want 0", wrap); end
    endtask

    task automatic test_depth6;
        total++; if (err6 !== 1'b0) begin bad++; $display("FAIL d6_err_init: got %b want 0", err6); end
        drv6 = 16'h5555; drv6_en = 1; latch6 = 1; wsel6 = 7;
        tick();
        latch6 = 0; drv6_en = 0;
        total++; if (reg_out6 !== 96'h0) begin bad++; $display("FAIL d6_regout: got %h want 0", reg_out6); end
        total++; if (err6 !== 1'b1) begin bad++; $display("FAIL d6_err_set: got %b want 1", err6); end
        tick();
        tick();
        total++; if (err6 !== 1'b1) begin bad++; $display("FAIL d6_err_sticky: got %b want 1", err6); end
        drv6 = 16'h0042; drv6_en = 1; latch6 = 1; wsel6 = 2;
        tick();
        latch6 = 0; drv6_en = 0;
        total++; if (reg6_of(2) !== 16'h0042) begin bad++; $display("FAIL d6_reg2: got %h want 0042", reg6_of(2)); end
        total++; if (err6 !== 1'b1) begin bad++; $display("FAIL d6_err_hold: got %b want 1", err6); end
        reset = 1;
        tick();
        reset = 0;
        total++; if (err6 !== 1'b0) begin bad++; $display("FAIL d6_err_clr: got %b want 0", err6); end
        total++; if (reg_out6 !== 96'h0) begin bad++; $display("FAIL d6_regout_clr: got %h want 0", reg_out6); end
        enable6 = 1; rsel6 = 7;
        #1;
        total++; if (DATA6 !== 16'h0000) begin bad++; $display("FAIL d6_bus_oor: got %h want 0000", DATA6); end
        tick();
        enable6 = 0;
        total++; if (err6 !== 1'b1) begin bad++; $display("FAIL d6_err_rsel: got %b want 1", err6); end
    endtask

    initial begin
        reset = 1; drv = '0; drv_en = 0;
        latch = 0; enable = 0; inc = 0; dec = 0; wsel = 0; rsel = 0; csel = 0;
        drv6 = '0; drv6_en = 0;
        latch6 = 0; enable6 = 0; inc6 = 0; dec6 = 0; wsel6 = 0; rsel6 = 0; csel6 = 0;

        test_reset();
        test_read_write();
        test_inc_wrap();
        test_dec_wrap();
        test_latch_priority();
        test_different_regs();
        test_self_drive();
        test_reset_mid_count();
        test_depth6();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
